// File: rtl/div_seq_if.sv
// Divide request/response bundle between EX (master) and the divide sequencer (slave).
// Carries operands, flush, stall request and the registered HI/LO result.
// No flow control beyond start/ready: EX holds start until it sees ready.
interface div_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             signed_div;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             cancel;
  logic             stall_req;
  logic             ready;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;

  modport master (
    output start, signed_div, dividend, divisor, cancel,
    input  stall_req, ready, quotient, remainder
  );

  modport slave (
    input  start, signed_div, dividend, divisor, cancel,
    output stall_req, ready, quotient, remainder
  );
endinterface

// File: rtl/div_seq.sv
// Restoring integer divider (DIV/DIVU), one quotient bit per cycle, result to HI/LO.
// Latency WIDTH+1 cycles from accepted start to ready (2 cycles for divide by zero).
// Holds the pipeline with stall_req while busy; result held in DONE until start drops.
module div_seq #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  div_seq_if.slave   bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, DIVZERO, BUSY, DONE} state_t;

  state_t           state, state_nxt;
  logic             stall;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem_r;     // partial remainder
  logic [WIDTH-1:0] dvd_r;     // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0] dvs_r;     // magnitude of divisor
  logic             neg_q;
  logic             neg_r;
  logic [WIDTH-1:0] q_r;
  logic [WIDTH-1:0] r_r;

  // Operand magnitudes: only signed divides take absolute values.
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] dvd_abs, dvs_abs;
  assign a_neg   = bus.signed_div & bus.dividend[WIDTH-1];
  assign b_neg   = bus.signed_div & bus.divisor[WIDTH-1];
  assign dvd_abs = a_neg ? -bus.dividend : bus.dividend;
  assign dvs_abs = b_neg ? -bus.divisor  : bus.divisor;

  // One restoring step; the partial needs an extra bit because an unsigned
  // divisor with its MSB set can still be exceeded after the shift.
  logic [WIDTH:0]   part;
  logic             ge;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] dvd_nxt;
  assign part    = {rem_r, dvd_r[WIDTH-1]};
  assign ge      = part >= {1'b0, dvs_r};
  assign rem_nxt = ge ? WIDTH'(part - {1'b0, dvs_r}) : part[WIDTH-1:0];
  assign dvd_nxt = {dvd_r[WIDTH-2:0], ge};

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and stall request; stall is combinational so EX freezes on the request cycle.
  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start && !bus.cancel) begin
          stall     = 1'b1;
          state_nxt = (bus.divisor == '0) ? DIVZERO : BUSY;
        end
      end
      DIVZERO: begin
        stall     = 1'b1;
        state_nxt = bus.cancel ? IDLE : DONE;
      end
      BUSY: begin
        stall = 1'b1;
        if (bus.cancel)       state_nxt = IDLE;
        else if (cnt == LAST) state_nxt = DONE;
      end
      DONE: begin
        if (!bus.start || bus.cancel) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: load on accept, iterate in BUSY, publish signed-fixed result on entry to DONE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt   <= '0;
      rem_r <= '0;
      dvd_r <= '0;
      dvs_r <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      q_r   <= '0;
      r_r   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start && !bus.cancel) begin
            cnt   <= '0;
            rem_r <= '0;
            dvd_r <= dvd_abs;
            dvs_r <= dvs_abs;
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
          end
        end
        DIVZERO: begin
          if (!bus.cancel) begin
            q_r <= '0;
            r_r <= '0;
          end
        end
        BUSY: begin
          if (!bus.cancel) begin
            rem_r <= rem_nxt;
            dvd_r <= dvd_nxt;
            cnt   <= cnt + CW'(1);
            if (cnt == LAST) begin
              q_r <= neg_q ? -dvd_nxt : dvd_nxt;
              r_r <= neg_r ? -rem_nxt : rem_nxt;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.stall_req = stall;
  assign bus.ready     = (state == DONE);
  assign bus.quotient  = q_r;
  assign bus.remainder = r_r;

endmodule

// File: doc/div_seq.md
# div_seq

Multi-cycle integer divide sequencer for the MIPS execute stage. It accepts a divide request from EX, computes quotient and remainder one bit per cycle with a restoring algorithm, and holds the pipeline via a stall request until the result is ready. Results go to EX, which writes HI (remainder) and LO (quotient).

## Interface

Parameters:
- WIDTH, 32, operand/result width in bits.

Ports:
- clk  in  1  pipeline clock; all state changes on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  divide request from EX; held high until ready is seen.
- signed_div  in  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with start in IDLE.
- dividend  in  WIDTH  operand A; sampled with start in IDLE.
- divisor  in  WIDTH  operand B; sampled with start in IDLE.
- cancel  in  1  flush request; aborts an in-progress divide.
- stall_req  out  1  request to the pipeline controller to freeze IF..EX.
- ready  out  1  result valid.
- quotient  out  WIDTH  quotient, goes to LO.
- remainder  out  WIDTH  remainder, goes to HI.

## Operation

- States: IDLE, DIVZERO, BUSY, DONE. Reset state is IDLE.
- IDLE: when start=1 and cancel=0, latch operands and signed_div.
  - If divisor==0, go to DIVZERO.
  - Otherwise load |dividend| and |divisor|, clear the bit counter, and go to BUSY. Absolute values are taken only when signed_div=1; unsigned operands are used raw.
- DIVZERO: go to DONE with quotient=0 and remainder=0. No exception is raised.
- BUSY: each cycle, shift the partial remainder left by one and bring in the next dividend bit, MSB first.
  - If partial ≥ divisor: subtract, quotient bit = 1.
  - Else: quotient bit = 0.
  - After WIDTH iterations (counter 0..WIDTH-1), go to DONE.
- Sign fixup on entry to DONE, when signed_div=1:
  - quotient is negated if dividend and divisor signs differ.
  - remainder takes the sign of the dividend.
  - All arithmetic is modulo 2^WIDTH. 0x80000000 / -1 yields quotient 0x80000000, remainder 0.
- DONE: ready=1. quotient and remainder are held stable.
  - Stay in DONE while start=1; no restart occurs.
  - When start=0, go to IDLE.
- cancel: in DIVZERO or BUSY, go to IDLE next cycle. ready is never asserted and outputs keep their prior values. cancel in DONE also returns to IDLE. cancel in IDLE blocks acceptance of start.
- stall_req = start in IDLE (when cancel=0), 1 in DIVZERO/BUSY, 0 in DONE. It is combinational from state and start, so EX is frozen in the same cycle as the request.
- Outputs are registered and only update on entry to DONE.

## Timing

- Reset values: state IDLE, ready 0, stall_req 0 (absent start), quotient 0, remainder 0, counter 0.
- Reset has priority over every input. Asserting it mid-BUSY returns the block to IDLE on the next edge with all outputs cleared.
- Nonzero divisor: start accepted at edge N (IDLE); BUSY occupies cycles N+1..N+WIDTH; ready=1 from cycle N+WIDTH+1. Latency is WIDTH+1 cycles, 33 for the default.
- Zero divisor: DIVZERO at N+1, ready=1 at N+2.
- stall_req falls in the same cycle ready rises, so EX captures the result at the next edge.
- Back-to-back divides need start low for at least one cycle; the next request is accepted from IDLE on the following edge.
- Simultaneous cancel and final BUSY iteration: cancel wins, and DONE is not entered.

## Test plan

- Unsigned 100 / 7, start at cycle 0 → stall_req high cycles 0–32; ready at cycle 33 with quotient=14, remainder=2; stall_req=0 at cycle 33.
- Signed -7 / 2 (0xFFFFFFF9 / 0x2) → quotient=0xFFFFFFFD, remainder=0xFFFFFFFF. Signed 7 / -2 → quotient=0xFFFFFFFD, remainder=1. Same operands unsigned 0xFFFFFFF9 / 2 → quotient=0x7FFFFFFC, remainder=1.
- Divide by zero: 5 / 0 → ready at cycle 2, quotient=0, remainder=0. Signed 0x80000000 / 0xFFFFFFFF → quotient=0x80000000, remainder=0 at cycle 33.
- Cancel at cycle 10 of BUSY → IDLE at cycle 11, ready stays 0 through cycle 40, outputs unchanged. A new 9 / 3 issued afterwards → quotient=3, remainder=0.
- rst_n low at cycle 15 mid-BUSY → at cycle 16: IDLE, ready=0, quotient=0, remainder=0, stall_req=start.
- start held 5 cycles in DONE → ready and results stable, no restart. start low 1 cycle, then 20 / 6 → accepted, quotient=3, remainder=2 after 33 cycles.
